// File: rtl/reflet_timer_multi.sv
// Multi-channel memory-mapped timer: per-channel prescaler, compare counter, one-shot/periodic
// mode, sticky W1C pending flag and a byte-0-triggered coherent count snapshot.
module reflet_timer_multi #(
  parameter int unsigned                base_addr_size = 16,
  parameter logic [base_addr_size-1:0]  base_addr      = base_addr_size'(16'hFF10),
  parameter int unsigned                channels       = 2,
  parameter int unsigned                counter_width  = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [base_addr_size-1:0] addr,
  input  logic                      write_en,
  input  logic [7:0]                data_in,
  output logic [7:0]                data_out,
  output logic                      interrupt,
  output logic [channels-1:0]       irq
);

  localparam int unsigned NumBytes = counter_width / 8;
  localparam logic [base_addr_size-1:0] WinSize = base_addr_size'(16 * channels);
  localparam logic [counter_width-1:0] CntOne = counter_width'(1);

  logic [base_addr_size-1:0] offset;
  logic                      sel;
  logic [1:0]                ch_idx;
  logic [3:0]                reg_idx;

  assign offset  = addr - base_addr;
  assign sel     = enable && (addr >= base_addr) && (offset < WinSize);
  assign ch_idx  = offset[5:4];
  assign reg_idx = offset[3:0];

  logic [channels-1:0]      run_q, run_d, oneshot_q, oneshot_d;
  logic [channels-1:0]      irq_en_q, irq_en_d, pending_q, pending_d;
  logic [7:0]               presc_q  [channels];
  logic [7:0]               presc_d  [channels];
  logic [7:0]               pcnt_q   [channels];
  logic [7:0]               pcnt_d   [channels];
  logic [counter_width-1:0] cmp_q    [channels];
  logic [counter_width-1:0] cmp_d    [channels];
  logic [counter_width-1:0] cnt_q    [channels];
  logic [counter_width-1:0] cnt_d    [channels];
  logic [counter_width-1:0] shadow_q [channels];
  logic [counter_width-1:0] shadow_d [channels];

  logic        wr_ch, rd_ch, tick, term, restart;
  logic [31:0] wr_ext;

  always_comb begin
    run_d     = run_q;
    oneshot_d = oneshot_q;
    irq_en_d  = irq_en_q;
    pending_d = pending_q;
    presc_d   = presc_q;
    pcnt_d    = pcnt_q;
    cmp_d     = cmp_q;
    cnt_d     = cnt_q;
    shadow_d  = shadow_q;
    wr_ch     = 1'b0;
    rd_ch     = 1'b0;
    tick      = 1'b0;
    term      = 1'b0;
    restart   = 1'b0;
    wr_ext    = '0;
    for (int i = 0; i < channels; i++) begin
      wr_ch   = sel && write_en && (ch_idx == 2'(i));
      rd_ch   = sel && !write_en && (ch_idx == 2'(i));
      tick    = 1'b0;
      term    = 1'b0;
      restart = 1'b0;
      wr_ext  = 32'(cmp_q[i]);

      if (run_q[i] && (cmp_q[i] != '0)) begin
        if (pcnt_q[i] == presc_q[i]) begin
          tick      = 1'b1;
          pcnt_d[i] = '0;
        end else begin
          pcnt_d[i] = pcnt_q[i] + 8'd1;
        end
        if (tick) begin
          if (cnt_q[i] == cmp_q[i] - CntOne) begin
            term     = 1'b1;
            cnt_d[i] = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CntOne;
          end
        end
      end

      if (term) begin
        pending_d[i] = 1'b1;
        if (oneshot_q[i]) run_d[i] = 1'b0;
      end

      // Bus writes come after the hardware update so a ctrl write beats a one-shot stop.
      if (wr_ch) begin
        case (reg_idx)
          4'd0: begin
            restart      = data_in[0] && !run_q[i];
            run_d[i]     = data_in[0];
            oneshot_d[i] = data_in[1];
            irq_en_d[i]  = data_in[2];
          end
          4'd1: if (data_in[0] && !term) pending_d[i] = 1'b0;
          4'd2: presc_d[i] = data_in;
          4'd4, 4'd5, 4'd6, 4'd7: begin
            if (32'(reg_idx[1:0]) < NumBytes) begin
              wr_ext[8*reg_idx[1:0] +: 8] = data_in;
              cmp_d[i] = wr_ext[counter_width-1:0];
              restart  = 1'b1;
            end
          end
          default: ;
        endcase
      end

      if (restart) begin
        pcnt_d[i] = '0;
        cnt_d[i]  = '0;
      end

      if (rd_ch && (reg_idx == 4'd8)) shadow_d[i] = cnt_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      run_q     <= '0;
      oneshot_q <= '0;
      irq_en_q  <= '0;
      pending_q <= '0;
      for (int i = 0; i < channels; i++) begin
        presc_q[i]  <= '0;
        pcnt_q[i]   <= '0;
        cmp_q[i]    <= '0;
        cnt_q[i]    <= '0;
        shadow_q[i] <= '0;
      end
    end else begin
      run_q     <= run_d;
      oneshot_q <= oneshot_d;
      irq_en_q  <= irq_en_d;
      pending_q <= pending_d;
      presc_q   <= presc_d;
      pcnt_q    <= pcnt_d;
      cmp_q     <= cmp_d;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
    end
  end

  logic [31:0] cmp_ext, cnt_ext, sh_ext;

  always_comb begin
    data_out = '0;
    cmp_ext  = '0;
    cnt_ext  = '0;
    sh_ext   = '0;
    if (sel && !reset) begin
      for (int i = 0; i < channels; i++) begin
        if (ch_idx == 2'(i)) begin
          cmp_ext = 32'(cmp_q[i]);
          cnt_ext = 32'(cnt_q[i]);
          sh_ext  = 32'(shadow_q[i]);
          case (reg_idx)
            4'd0:                   data_out = {5'b0, irq_en_q[i], oneshot_q[i], run_q[i]};
            4'd1:                   data_out = {7'b0, pending_q[i]};
            4'd2:                   data_out = presc_q[i];
            4'd4, 4'd5, 4'd6, 4'd7: data_out = cmp_ext[8*reg_idx[1:0] +: 8];
            4'd8:                   data_out = cnt_ext[7:0];
            4'd9, 4'd10, 4'd11:     data_out = sh_ext[8*reg_idx[1:0] +: 8];
            default:                data_out = '0;
          endcase
        end
      end
    end
  end

  assign irq       = pending_q & irq_en_q;
  assign interrupt = |irq;

endmodule

// File: tb/tb_reflet_timer_multi.sv
// Directed bench for reflet_timer_multi (2 channels, 16-bit counters, window at 0xFF10).
module tb_reflet_timer_multi;

  logic        clk = 1'b0;
  logic        reset, enable, write_en;
  logic [15:0] addr;
  logic [7:0]  data_in, data_out;
  logic        interrupt;
  logic [1:0]  irq;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  reflet_timer_multi #(
    .base_addr_size(16),
    .base_addr     (16'hFF10),
    .channels      (2),
    .counter_width (16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .addr     (addr),
    .write_en (write_en),
    .data_in  (data_in),
    .data_out (data_out),
    .interrupt(interrupt),
    .irq      (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        en;
    logic        we;
    logic [15:0] a;
    logic [7:0]  d;
    logic [7:0]  exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic en, input logic we, input logic [15:0] a, input logic [7:0] d,
                      input logic [7:0] exp);
    vec_t v;
    v.en = en; v.we = we; v.a = a; v.d = d; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    enable = 1'b1; write_en = 1'b1; addr = a; data_in = d;
    @(posedge clk);
    #1;
    enable = 1'b0; write_en = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, input logic [7:0] exp, input string name);
    enable = 1'b1; write_en = 1'b0; addr = a;
    #1;
    check(name, data_out, exp);
    @(posedge clk);
    #1;
    enable = 1'b0;
  endtask

  task automatic wait_irq(input int idx, input int bound, output int at);
    at = -1;
    for (int k = 0; k < bound; k++) begin
      @(posedge clk);
      #1;
      if (irq[idx]) begin
        at = cyc;
        break;
      end
    end
  endtask

  initial begin
    int c0, r1, r2, r3;
    reset = 1'b1; enable = 1'b0; write_en = 1'b0; addr = '0; data_in = '0;
    idle(2);
    reset = 1'b0;

    // Reset state of every register, then register read-back on a stopped channel 1.
    for (int i = 0; i < 32; i++) push(1'b1, 1'b0, 16'hFF10 + 16'(i), 8'h00, 8'h00);
    push(1'b1, 1'b1, 16'hFF22, 8'hAB, 8'h00);
    push(1'b1, 1'b0, 16'hFF22, 8'h00, 8'hAB);
    push(1'b0, 1'b0, 16'hFF22, 8'h00, 8'h00);  // enable low
    push(1'b1, 1'b0, 16'hFF62, 8'h00, 8'h00);  // alias outside window
    push(1'b1, 1'b0, 16'hFF0F, 8'h00, 8'h00);
    push(1'b1, 1'b1, 16'hFF24, 8'h34, 8'h00);
    push(1'b1, 1'b1, 16'hFF25, 8'h12, 8'h00);
    push(1'b1, 1'b1, 16'hFF26, 8'h77, 8'h00);
    push(1'b1, 1'b0, 16'hFF24, 8'h00, 8'h34);
    push(1'b1, 1'b0, 16'hFF25, 8'h00, 8'h12);
    push(1'b1, 1'b0, 16'hFF26, 8'h00, 8'h00);
    push(1'b1, 1'b0, 16'hFF27, 8'h00, 8'h00);
    push(1'b1, 1'b1, 16'hFF20, 8'hFA, 8'h00);
    push(1'b1, 1'b0, 16'hFF20, 8'h00, 8'h02);
    push(1'b1, 1'b1, 16'hFF23, 8'h55, 8'h00);
    push(1'b1, 1'b0, 16'hFF23, 8'h00, 8'h00);
    push(1'b1, 1'b0, 16'hFF28, 8'h00, 8'h00);
    push(1'b1, 1'b1, 16'hFF20, 8'h00, 8'h00);
    push(1'b1, 1'b1, 16'hFF24, 8'h00, 8'h00);
    push(1'b1, 1'b1, 16'hFF25, 8'h00, 8'h00);
    push(1'b1, 1'b0, 16'hFF25, 8'h00, 8'h00);

    check("reset_interrupt", interrupt, 1'b0);
    foreach (vecs[i]) begin
      enable = vecs[i].en; write_en = vecs[i].we; addr = vecs[i].a; data_in = vecs[i].d;
      #1;
      if (!vecs[i].we) check($sformatf("vec%0d_data_out", i), data_out, vecs[i].exp);
      check($sformatf("vec%0d_irq", i), irq, 2'b00);
      @(posedge clk);
      #1;
    end
    enable = 1'b0; write_en = 1'b0;

    // Periodic ch0: (3+1)*5 = 20 cycle period.
    wr(16'hFF12, 8'h03);
    wr(16'hFF14, 8'h05);
    wr(16'hFF10, 8'h05);
    c0 = cyc;
    wait_irq(0, 100, r1);
    check("periodic_first", r1 - c0, 20);
    check("periodic_interrupt", interrupt, 1'b1);
    wr(16'hFF11, 8'h01);
    check("periodic_cleared", irq[0], 1'b0);
    wait_irq(0, 100, r2);
    check("periodic_period1", r2 - r1, 20);
    wr(16'hFF11, 8'h01);
    wait_irq(0, 100, r3);
    check("periodic_period2", r3 - r2, 20);
    wr(16'hFF10, 8'h00);
    wr(16'hFF11, 8'h01);

    // One-shot ch1: 10 cycles, then run drops.
    wr(16'hFF22, 8'h00);
    wr(16'hFF24, 8'h0A);
    wr(16'hFF20, 8'h07);
    c0 = cyc;
    wait_irq(1, 100, r1);
    check("oneshot_delay", r1 - c0, 10);
    rd(16'hFF20, 8'h06, "oneshot_ctrl");
    rd(16'hFF28, 8'h00, "oneshot_count");
    wr(16'hFF21, 8'h01);
    idle(30);
    check("oneshot_no_repeat", irq, 2'b00);
    rd(16'hFF21, 8'h00, "oneshot_pending");

    // Coherent snapshot on ch0, compare 0x1000, prescaler 0.
    wr(16'hFF12, 8'h00);
    wr(16'hFF14, 8'h00);
    wr(16'hFF15, 8'h10);
    wr(16'hFF10, 8'h01);
    idle(255);
    rd(16'hFF18, 8'hFF, "snap_byte0");
    idle(1);
    rd(16'hFF19, 8'h00, "snap_byte1");
    rd(16'hFF18, 8'h02, "snap_byte0_again");
    rd(16'hFF19, 8'h01, "snap_byte1_again");

    // Compare write mid-count restarts; run=0 freezes without clearing.
    wr(16'hFF14, 8'h00);
    rd(16'hFF18, 8'h00, "restart_count0");
    idle(3);
    rd(16'hFF18, 8'h04, "restart_count4");
    wr(16'hFF10, 8'h00);
    rd(16'hFF18, 8'h06, "freeze_count");
    idle(2);
    rd(16'hFF18, 8'h06, "freeze_hold");

    // compare == 0 with run=1 on ch1: frozen, no irq.
    wr(16'hFF24, 8'h00);
    wr(16'hFF20, 8'h05);
    idle(30);
    rd(16'hFF28, 8'h00, "cmp0_count");
    check("cmp0_irq", irq, 2'b00);
    wr(16'hFF20, 8'h00);

    // Clear issued on the terminal-tick cycle: set wins.
    wr(16'hFF14, 8'h04);
    wr(16'hFF15, 8'h00);
    wr(16'hFF10, 8'h05);
    idle(3);
    wr(16'hFF11, 8'h01);
    check("set_wins_irq", irq[0], 1'b1);
    wr(16'hFF11, 8'h01);
    check("clear_after_irq", irq[0], 1'b0);
    wr(16'hFF10, 8'h00);
    wr(16'hFF11, 8'h01);

    // Ctrl write on a one-shot terminal tick keeps the written run bit.
    wr(16'hFF24, 8'h03);
    wr(16'hFF20, 8'h03);
    idle(2);
    wr(16'hFF20, 8'h03);
    rd(16'hFF20, 8'h03, "ctrl_write_wins");
    idle(3);
    rd(16'hFF20, 8'h02, "oneshot_second_stop");
    wr(16'hFF21, 8'h01);

    // Reset mid-count with a concurrent bus write.
    wr(16'hFF10, 8'h05);
    idle(6);
    check("pre_reset_irq", irq[0], 1'b1);
    reset = 1'b1; enable = 1'b1; write_en = 1'b1; addr = 16'hFF12; data_in = 8'hEE;
    @(posedge clk);
    #1;
    reset = 1'b0; enable = 1'b0; write_en = 1'b0;
    check("post_reset_irq", irq, 2'b00);
    check("post_reset_interrupt", interrupt, 1'b0);
    for (int i = 0; i < 32; i++) rd(16'hFF10 + 16'(i), 8'h00, $sformatf("post_reset_reg%0d", i));
    rd(16'hFF40, 8'h00, "out_of_window");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
